match_controller: RTL and testbench



---
 rtl/match_controller.sv | 176 +++++++++++++++++
 tb/tb_match_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Best-of-N match sequencer: intro countdown, fight, round-end pause, match-end hold.
// Define PAUSE_EN to add the i_pause_req port and the PAUSED phase.
module match_controller #(
  parameter int INTRO_FRAMES = 90,
  parameter int PAUSE_FRAMES = 120,
  parameter int WINS_NEEDED  = 2,
  parameter int MAX_ROUNDS   = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_start,
  input  logic       i_game_over,
  input  logic [1:0] i_health1,
  input  logic [1:0] i_health2,
  input  logic [7:0] i_time_left,
`ifdef PAUSE_EN
  input  logic       i_pause_req,
`endif
  output logic       o_round_rst,
  output logic       o_play_en,
  output logic [2:0] o_phase,
  output logic [2:0] o_round_num,
  output logic [1:0] o_wins1,
  output logic [1:0] o_wins2,
  output logic [1:0] o_round_winner,
  output logic [1:0] o_match_winner
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INTRO     = 3'd1,
    S_FIGHT     = 3'd2,
    S_ROUND_END = 3'd3,
    S_MATCH_END = 3'd4,
    S_PAUSED    = 3'd5
  } state_t;

  localparam logic [7:0] L_INTRO  = 8'(INTRO_FRAMES);
  localparam logic [7:0] L_PAUSE  = 8'(PAUSE_FRAMES);
  localparam logic [1:0] L_WINS   = 2'(WINS_NEEDED);
  localparam logic [2:0] L_ROUNDS = 3'(MAX_ROUNDS);

  state_t     r_state, w_state;
  logic [7:0] r_count, w_count;
  logic [2:0] r_round_num, w_round_num;
  logic [1:0] r_wins1, w_wins1, r_wins2, w_wins2;
  logic [1:0] r_round_winner, w_round_winner;
  logic [1:0] r_match_winner, w_match_winner;
  logic       r_play_en, w_play_en, r_round_rst, w_round_rst;
  logic [7:0] w_count_dec;
  logic [1:0] w_verdict;

  // Time-out rounds are resolved by health alone, so the timer value carries no extra information.
  logic w_unused_time;
  assign w_unused_time = ^i_time_left;

  assign w_count_dec = (r_count != 8'd0) ? r_count - 8'd1 : r_count;

  always_comb begin
    w_verdict = 2'd3;
    if (i_health1 == 2'd0 && i_health2 == 2'd0) w_verdict = 2'd3;
    else if (i_health2 == 2'd0)                 w_verdict = 2'd1;
    else if (i_health1 == 2'd0)                 w_verdict = 2'd2;
    else if (i_health1 > i_health2)             w_verdict = 2'd1;
    else if (i_health2 > i_health1)             w_verdict = 2'd2;
  end

  always_comb begin
    w_state        = r_state;
    w_count        = r_count;
    w_round_num    = r_round_num;
    w_wins1        = r_wins1;
    w_wins2        = r_wins2;
    w_round_winner = r_round_winner;
    w_match_winner = r_match_winner;
    w_round_rst    = 1'b0;
    case (r_state)
      S_IDLE, S_MATCH_END: begin
        if (i_start) begin
          w_state        = S_INTRO;
          w_round_num    = 3'd1;
          w_wins1        = 2'd0;
          w_wins2        = 2'd0;
          w_round_winner = 2'd0;
          w_match_winner = 2'd0;
          w_round_rst    = 1'b1;
          w_count        = L_INTRO;
        end
      end
      S_INTRO: begin
        if (i_frame_tick) begin
          w_count = w_count_dec;
          if (r_count == 8'd1) w_state = S_FIGHT;
        end
      end
      S_FIGHT: begin
        if (i_game_over) begin
          w_state        = S_ROUND_END;
          w_round_winner = w_verdict;
          w_count        = L_PAUSE;
          if (w_verdict == 2'd1 && r_wins1 != 2'd3) w_wins1 = r_wins1 + 2'd1;
          if (w_verdict == 2'd2 && r_wins2 != 2'd3) w_wins2 = r_wins2 + 2'd1;
        end
`ifdef PAUSE_EN
        else if (i_pause_req) begin
          w_state = S_PAUSED;
        end
`endif
      end
      S_ROUND_END: begin
        if (i_frame_tick) begin
          w_count = w_count_dec;
          if (r_count == 8'd1) begin
            if (r_wins1 == L_WINS) begin
              w_state        = S_MATCH_END;
              w_match_winner = 2'd1;
            end else if (r_wins2 == L_WINS) begin
              w_state        = S_MATCH_END;
              w_match_winner = 2'd2;
            end else if (r_round_num == L_ROUNDS) begin
              w_state        = S_MATCH_END;
              w_match_winner = 2'd3;
            end else begin
              w_state     = S_INTRO;
              w_round_num = r_round_num + 3'd1;
              w_round_rst = 1'b1;
              w_count     = L_INTRO;
            end
          end
        end
      end
`ifdef PAUSE_EN
      S_PAUSED: begin
        if (i_pause_req) w_state = S_FIGHT;
      end
`endif
      default: w_state = S_IDLE;
    endcase
    w_play_en = (w_state == S_FIGHT);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_count        <= 8'd0;
      r_round_num    <= 3'd0;
      r_wins1        <= 2'd0;
      r_wins2        <= 2'd0;
      r_round_winner <= 2'd0;
      r_match_winner <= 2'd0;
      r_play_en      <= 1'b0;
      r_round_rst    <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_count        <= w_count;
      r_round_num    <= w_round_num;
      r_wins1        <= w_wins1;
      r_wins2        <= w_wins2;
      r_round_winner <= w_round_winner;
      r_match_winner <= w_match_winner;
      r_play_en      <= w_play_en;
      r_round_rst    <= w_round_rst;
    end
  end

  assign o_phase        = r_state;
  assign o_round_num    = r_round_num;
  assign o_wins1        = r_wins1;
  assign o_wins2        = r_wins2;
  assign o_round_winner = r_round_winner;
  assign o_match_winner = r_match_winner;
  assign o_play_en      = r_play_en;
  assign o_round_rst    = r_round_rst;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a queue-based scoreboard of expected outputs.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       frameTick, start, gameOver;
  logic [1:0] health1, health2;
  logic [7:0] timeLeft;
`ifdef PAUSE_EN
  logic       pauseReq;
`endif
  logic       roundRst, playEn;
  logic [2:0] phase, roundNum;
  logic [1:0] wins1, wins2, roundWinner, matchWinner;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    string      tag;
    logic [2:0] phase;
    logic [2:0] roundNum;
    logic [1:0] wins1;
    logic [1:0] wins2;
    logic [1:0] roundWinner;
    logic [1:0] matchWinner;
    logic       playEn;
    logic       roundRst;
  } expect_t;

  expect_t sbQueue[$];

  match_controller #(
    .INTRO_FRAMES(3),
    .PAUSE_FRAMES(2),
    .WINS_NEEDED (2),
    .MAX_ROUNDS  (3)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_tick  (frameTick),
    .i_start       (start),
    .i_game_over   (gameOver),
    .i_health1     (health1),
    .i_health2     (health2),
    .i_time_left   (timeLeft),
`ifdef PAUSE_EN
    .i_pause_req   (pauseReq),
`endif
    .o_round_rst   (roundRst),
    .o_play_en     (playEn),
    .o_phase       (phase),
    .o_round_num   (roundNum),
    .o_wins1       (wins1),
    .o_wins2       (wins2),
    .o_round_winner(roundWinner),
    .o_match_winner(matchWinner)
  );

  always #5 clk = ~clk;

  task automatic pushExpect(input string tag, input logic [2:0] ph, input logic [2:0] rn,
                            input logic [1:0] w1, input logic [1:0] w2, input logic [1:0] rw,
                            input logic [1:0] mw, input logic pe, input logic rr);
    expect_t e;
    e.tag = tag; e.phase = ph; e.roundNum = rn; e.wins1 = w1; e.wins2 = w2;
    e.roundWinner = rw; e.matchWinner = mw; e.playEn = pe; e.roundRst = rr;
    sbQueue.push_back(e);
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [7:0] observed, input logic [7:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, observed, expected);
    end
  endtask

  task automatic checkOutput;
    expect_t e;
    if (sbQueue.size() == 0) begin
      testsRun++;
      testsFailed++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sbQueue.pop_front();
      checkField(e.tag, "phase",       {5'd0, phase},       {5'd0, e.phase});
      checkField(e.tag, "roundNum",    {5'd0, roundNum},    {5'd0, e.roundNum});
      checkField(e.tag, "wins1",       {6'd0, wins1},       {6'd0, e.wins1});
      checkField(e.tag, "wins2",       {6'd0, wins2},       {6'd0, e.wins2});
      checkField(e.tag, "roundWinner", {6'd0, roundWinner}, {6'd0, e.roundWinner});
      checkField(e.tag, "matchWinner", {6'd0, matchWinner}, {6'd0, e.matchWinner});
      checkField(e.tag, "playEn",      {7'd0, playEn},      {7'd0, e.playEn});
      checkField(e.tag, "roundRst",    {7'd0, roundRst},    {7'd0, e.roundRst});
    end
  endtask

  task automatic applyStimulus(input logic st, input logic tk, input logic go,
                               input logic [1:0] h1, input logic [1:0] h2, input logic [7:0] tl);
    start = st; frameTick = tk; gameOver = go;
    health1 = h1; health2 = h2; timeLeft = tl;
    @(posedge clk);
    #1;
    start = 1'b0; frameTick = 1'b0; gameOver = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, health1, health2, timeLeft);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; frameTick = 1'b0; gameOver = 1'b0;
    health1 = 2'd3; health2 = 2'd3; timeLeft = 8'd60;
`ifdef PAUSE_EN
    pauseReq = 1'b0;
`endif
    @(posedge clk); #1; @(posedge clk); #1;
    pushExpect("reset", 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    rst = 1'b0;

    // Match 1: P1 takes two rounds
    applyStimulus(1, 0, 0, 3, 3, 60);
    pushExpect("start", 1, 1, 0, 0, 0, 0, 0, 1); checkOutput();
    applyStimulus(0, 0, 0, 3, 3, 60);
    pushExpect("rrOnce", 1, 1, 0, 0, 0, 0, 0, 0); checkOutput();
    ticks(2);
    pushExpect("introHold", 1, 1, 0, 0, 0, 0, 0, 0); checkOutput();
    ticks(1);
    pushExpect("fight1", 2, 1, 0, 0, 0, 0, 1, 0); checkOutput();
    applyStimulus(0, 0, 1, 2, 0, 40);
    pushExpect("koP1", 3, 1, 1, 0, 1, 0, 0, 0); checkOutput();
    ticks(1);
    pushExpect("pause1", 3, 1, 1, 0, 1, 0, 0, 0); checkOutput();
    ticks(1);
    pushExpect("round2", 1, 2, 1, 0, 1, 0, 0, 1); checkOutput();
    applyStimulus(0, 1, 1, 0, 3, 0);
    pushExpect("staleGameOver", 1, 2, 1, 0, 1, 0, 0, 0); checkOutput();
    ticks(1);
    pushExpect("intro2", 1, 2, 1, 0, 1, 0, 0, 0); checkOutput();
    ticks(1);
    pushExpect("fight2", 2, 2, 1, 0, 1, 0, 1, 0); checkOutput();
    applyStimulus(0, 1, 1, 3, 1, 0);
    pushExpect("timeoutP1", 3, 2, 2, 0, 1, 0, 0, 0); checkOutput();
    ticks(1);
    pushExpect("pause2", 3, 2, 2, 0, 1, 0, 0, 0); checkOutput();
    ticks(1);
    pushExpect("matchP1", 4, 2, 2, 0, 1, 1, 0, 0); checkOutput();
    ticks(1);
    pushExpect("matchHold", 4, 2, 2, 0, 1, 1, 0, 0); checkOutput();

    // Match 2: three timeout draws
    applyStimulus(1, 0, 0, 2, 2, 0);
    pushExpect("restart", 1, 1, 0, 0, 0, 0, 0, 1); checkOutput();
    for (int r = 1; r <= 3; r++) begin
      ticks(2);
      pushExpect("drawIntro", 1, 3'(r), 0, 0, (r == 1) ? 2'd0 : 2'd3, 0, 0, 0); checkOutput();
      ticks(1);
      pushExpect("drawFight", 2, 3'(r), 0, 0, (r == 1) ? 2'd0 : 2'd3, 0, 1, 0); checkOutput();
      applyStimulus(0, 0, 1, 2, 2, 0);
      pushExpect("drawEnd", 3, 3'(r), 0, 0, 3, 0, 0, 0); checkOutput();
      ticks(2);
      if (r < 3) begin
        pushExpect("drawNext", 1, 3'(r + 1), 0, 0, 3, 0, 0, 1); checkOutput();
      end else begin
        pushExpect("matchDraw", 4, 3, 0, 0, 3, 3, 0, 0); checkOutput();
      end
    end

    // Asynchronous reset during INTRO
    applyStimulus(1, 0, 0, 3, 3, 60);
    pushExpect("start3", 1, 1, 0, 0, 0, 0, 0, 1); checkOutput();
    rst = 1'b1; #1;
    pushExpect("rstIntro", 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    @(negedge clk); rst = 1'b0;
    applyStimulus(0, 1, 0, 3, 3, 60);
    pushExpect("idleAfterRst", 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();

    // P2 round win, then asynchronous reset during ROUND_END
    applyStimulus(1, 0, 0, 3, 3, 60);
    pushExpect("start4", 1, 1, 0, 0, 0, 0, 0, 1); checkOutput();
    ticks(3);
    pushExpect("fight4", 2, 1, 0, 0, 0, 0, 1, 0); checkOutput();
    applyStimulus(0, 0, 1, 0, 3, 20);
    pushExpect("koP2", 3, 1, 0, 1, 2, 0, 0, 0); checkOutput();
    rst = 1'b1; #1;
    pushExpect("rstRoundEnd", 0, 0, 0, 0, 0, 0, 0, 0); checkOutput();
    @(negedge clk); rst = 1'b0;

`ifdef PAUSE_EN
    applyStimulus(1, 0, 0, 3, 3, 60);
    ticks(3);
    pushExpect("fight5", 2, 1, 0, 0, 0, 0, 1, 0); checkOutput();
    pauseReq = 1'b1;
    applyStimulus(0, 0, 0, 3, 3, 60);
    pauseReq = 1'b0;
    pushExpect("paused", 5, 1, 0, 0, 0, 0, 0, 0); checkOutput();
    applyStimulus(0, 0, 1, 3, 0, 60);
    pushExpect("pausedGameOver", 5, 1, 0, 0, 0, 0, 0, 0); checkOutput();
    pauseReq = 1'b1;
    applyStimulus(0, 0, 0, 3, 3, 60);
    pauseReq = 1'b0;
    pushExpect("resume", 2, 1, 0, 0, 0, 0, 1, 0); checkOutput();
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
